// File: rtl/core_l1d_pkg.sv
// core_l1d_pkg: definitions shared by the L1 data-side request interface.
// The MEM-stage requester and the SRAM responder (l1d_sram_resp) both use it.
// Contents:
//   COP_WR_BIT / COP_UNC_BIT : bit positions inside the 3-bit req_cop field
//   SZ_BYTE / SZ_HALF / SZ_WORD : req_size encodings (other codes act as word)
//   l1d_resp_state_t          : responder FSM states
//   lane_offset / byte_enables / size_mask : lane helpers for sub-word accesses
package core_l1d_pkg;

  localparam int COP_WR_BIT  = 0;
  localparam int COP_UNC_BIT = 1;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } l1d_resp_state_t;

  // Byte lane of the access. Halves drop addr[0] and words drop addr[1:0],
  // so a misaligned access (when not flagged) lands on the aligned lane.
  function automatic logic [1:0] lane_offset(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SZ_BYTE: off = addr_lo;
      SZ_HALF: off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] size_mask(input logic [2:0] size);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/l1d_sram_resp_sram.sv
// l1d_resp_sram: single-port 32-bit-wide SRAM with per-byte write enables
// and a registered (synchronous) read. Contents are never reset.
// Parameters: DEPTH_WORDS - number of 32-bit words (power of 2, >= 2).
// Ports:
//   clk   in  : clock
//   en    in  : access enable for this cycle
//   we    in  : 1 = write (byte-enabled), 0 = read
//   be    in  : byte enables, bit i writes wdata[8i+7:8i]
//   idx   in  : word index
//   wdata in  : lane-aligned write data
//   rdata out : word read by the last enabled read; holds otherwise
module l1d_resp_sram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-enabled write and synchronous read; the read register holds between reads.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (en && !we) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l1d_sram_resp.sv
// l1d_sram_resp: responder end of the L1 data request/acknowledge interface.
// Accepts one load/store at a time, waits WAIT_CYCLES, performs the SRAM
// access and returns a one-cycle ack with right-aligned, zero-extended data.
// Request sampled at edge T -> ack is the value sampled at edge T+WAIT_CYCLES+2.
// Optional feature macro: L1D_RESP_MISALIGN_CHK_EN
//   defined   : misaligned half/word accesses skip the SRAM and report resp_err
//   undefined : misaligned accesses are forced onto the aligned lane, resp_err=0
// Parameters: DEPTH_WORDS (power of 2), WAIT_CYCLES (0..15).
// Ports:
//   clk, rst      in  : clock, synchronous active-high reset
//   req_val       in  : request valid, held until ack
//   req_addr      in  : byte address (upper bits alias)
//   req_cop       in  : bit0 write, bit1 uncacheable hint (ignored), bit2 reserved
//   req_wdata     in  : right-aligned store data
//   req_size      in  : byte / half / word (other codes = word)
//   ack           out : one-cycle response pulse
//   rdata         out : read data while ack, 0 otherwise and for writes
//   resp_err      out : misaligned-access flag, valid with ack
module l1d_sram_resp
  import core_l1d_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_cop,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  l1d_resp_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      cop_q, cop_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      size_q, size_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic            misalign_s;
  logic [1:0]      off_s;
  logic            sram_en_s;
  logic [3:0]      sram_be_s;
  logic [31:0]     sram_wdata_s;
  logic [31:0]     sram_rdata_s;
  logic [31:0]     shifted_s;
  logic            unused_s;

  // Misalignment detection on the latched request.
  always_comb begin
`ifdef L1D_RESP_MISALIGN_CHK_EN
    if (size_q == SZ_BYTE) begin
      misalign_s = 1'b0;
    end else if (size_q == SZ_HALF) begin
      misalign_s = addr_q[0];
    end else begin
      misalign_s = (addr_q[1:0] != 2'b00);
    end
`else
    misalign_s = 1'b0;
`endif
  end

  // Next-state, counter and request-latch logic of the responder FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    cop_d   = cop_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          addr_d  = req_addr;
          cop_d   = req_cop;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = WAIT_LD;
          if (WAIT_LD != 4'd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // The counter holds the wait cycles still to spend, including this one.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        // ack/err are registered here so they are high throughout RESP.
        state_d = ST_RESP;
        ack_d   = 1'b1;
        err_d   = misalign_s;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request latch and response flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      cop_q   <= 3'b000;
      wdata_q <= 32'h0;
      size_q  <= 3'b000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cop_q   <= cop_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign off_s        = lane_offset(size_q, addr_q[1:0]);
  assign sram_be_s    = byte_enables(size_q, off_s);
  assign sram_wdata_s = wdata_q << {off_s, 3'b000};
  // rst gates the enable so a reset landing on ACCESS never commits a write.
  assign sram_en_s    = (state_q == ST_ACCESS) && !misalign_s && !rst;

  l1d_resp_sram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en_s),
    .we    (cop_q[COP_WR_BIT]),
    .be    (sram_be_s),
    .idx   (addr_q[AW+1:2]),
    .wdata (sram_wdata_s),
    .rdata (sram_rdata_s)
  );

  // Read data alignment: the SRAM word is valid in RESP, the lane comes from the latch.
  always_comb begin
    shifted_s = sram_rdata_s >> {off_s, 3'b000};
    if (ack_q && !cop_q[COP_WR_BIT] && !err_q) begin
      rdata = shifted_s & size_mask(size_q);
    end else begin
      rdata = 32'h0;
    end
  end

  assign ack      = ack_q;
  assign resp_err = err_q;

  // Aliased address bits and the hint/reserved cop bits carry no function here.
  assign unused_s = ^{addr_q[31:AW+2], cop_q[COP_UNC_BIT], cop_q[2]};

endmodule

// File: doc/l1d_sram_resp.md
# l1d_sram_resp

Responder end of the core's L1 data request/acknowledge interface. It accepts one load or store at a time from the MEM stage (`req_val`/`addr`/`cop`/`wdata`/`size`) and services it from an on-chip byte-addressable SRAM after a programmable number of wait states. It returns a single-cycle `ack` with right-aligned, zero-extended read data, which the WB stage then sign-extends. It serves as the data-side memory in core-level simulation and FPGA builds.

## Interface
- `DEPTH_WORDS`, default 1024: SRAM depth in 32-bit words; must be a power of 2.
- `WAIT_CYCLES`, default 1: wait states inserted before the access; range 0..15.
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `req_val` in 1: request valid; held stable by the requester until `ack`.
- `req_addr` in 32: byte address.
- `req_cop` in 3: operation code.
  - bit0: 1 = write, 0 = read.
  - bit1: uncacheable hint, ignored here.
  - bit2: reserved, 0.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size` in 3: 3'b000 byte, 3'b001 half, 3'b010 word; other codes are treated as word.
- `ack` out 1: one-cycle response pulse.
- `rdata` out 32: read data, right-aligned and zero-extended; valid only while `ack`=1; 0 for writes.
- `resp_err` out 1: misaligned access flag; valid with `ack`. Exists only with `L1D_RESP_MISALIGN_CHK_EN`; otherwise tied to 0.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE, `req_val`=1:
  - latch addr, cop, wdata and size;
  - load wait counter with `WAIT_CYCLES`;
  - go to WAIT if `WAIT_CYCLES`>0, else to ACCESS.
- WAIT: decrement the counter; go to ACCESS when it reaches 1.
- ACCESS:
  - word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses alias/wrap.
  - Write: shift wdata into lane addr[1:0]. Byte enables are 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, 4'b1111 for word. Commit at the end of the ACCESS cycle.
  - Read: issue a synchronous SRAM read.
  - Go to RESP.
- RESP:
  - `ack`=1.
  - For reads, `rdata` = SRAM word >> (8*addr[1:0]), masked to size.
  - Return to IDLE.
- Later changes to the request inputs while busy are ignored; the block uses only the latched copy.
- A request still present in IDLE after `ack` is treated as a new request. The requester must drop or replace `req_val` in the cycle after `ack`.
- SRAM contents are not reset.

## Timing
- Request sampled at edge T (IDLE, `req_val`=1) → `ack` high during cycle T+`WAIT_CYCLES`+2, for exactly one cycle.
- Throughput: one request per `WAIT_CYCLES`+3 cycles.
- Reset values: state IDLE, counter 0, `ack`=0, `rdata`=0, `resp_err`=0.
- `rst` mid-operation: return to IDLE on the next edge, no `ack`, no write commit. If reset coincides with ACCESS, the write is suppressed.
- `req_val` during `rst` is ignored.
- Read-after-write to the same word on back-to-back requests returns the new data (the write commits before the next read issues).

## Configuration
- `L1D_RESP_MISALIGN_CHK_EN` defined:
  - half with addr[0]=1, or word with addr[1:0]≠0, skips the SRAM access (no write, no read);
  - `ack` arrives with the same latency as a normal access, `rdata`=0, `resp_err`=1.
- Undefined:
  - addr[0] is forced to 0 for half and addr[1:0] to 0 for word before lane selection;
  - the access proceeds normally;
  - `resp_err` is constant 0.

## Structure
- Shared package `core_l1d_pkg` holds:
  - cop bit positions (`COP_WR_BIT`, `COP_UNC_BIT`);
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - FSM state enum `l1d_resp_state_t`.
- The pipeline-side MEM stage uses the same package.
- Sub-module `l1d_resp_sram`: single-port, byte-enable write, synchronous read; parameter `DEPTH_WORDS`; no reset.
- Byte-enable generation, lane shift and FSM stay in the top module.

## Test plan
- `WAIT_CYCLES`=1: write word 0xDEADBEEF @0x10, then read word @0x10 → `ack` 3 cycles after each sample, `rdata`=0xDEADBEEF.
- Write byte 0xA5 @0x13, then read word @0x10 → `rdata`=0xA5ADBEEF; read byte @0x13 → 0x000000A5; read half @0x12 → 0x0000A5AD.
- `WAIT_CYCLES`=0 and =15: `ack` exactly at T+2 and T+17; `req_wdata` toggled mid-wait does not alter the stored data.
- Assert `rst` during WAIT of a write of 0x12345678 @0x20 → no `ack`; a subsequent read @0x20 returns the prior content (0 after init-by-write of 0).
- With `L1D_RESP_MISALIGN_CHK_EN`: write word 0xFFFFFFFF @0x21 → `ack`, `resp_err`=1, word @0x20 unchanged. Without it: same stimulus writes 0xFFFFFFFF @0x20 and `resp_err`=0.
- `req_val` held high after `ack` with `DEPTH_WORDS`=1024: address 0x1010 aliases 0x0010; the held request is re-serviced and a second `ack` arrives `WAIT_CYCLES`+3 cycles later.
